// File: rtl/fifo_csr_pkg.sv
// -----------------------------------------------------------------------------
// fifo_csr_pkg
// Shared constants for the FIFO CSR block: Avalon register addresses,
// IRQ_STATUS / IRQ_MASK bit positions and STATUS register field offsets.
// -----------------------------------------------------------------------------
package fifo_csr_pkg;

   // Register map (avalon_address)
   localparam logic [2:0] STATUS     = 3'd0;
   localparam logic [2:0] DATA       = 3'd1;
   localparam logic [2:0] AF_THRESH  = 3'd2;
   localparam logic [2:0] AE_THRESH  = 3'd3;
   localparam logic [2:0] IRQ_MASK   = 3'd4;
   localparam logic [2:0] IRQ_STATUS = 3'd5;
   localparam logic [2:0] CONTROL    = 3'd6;

   // IRQ_STATUS / IRQ_MASK bit indices
   localparam int unsigned IRQ_OVERFLOW  = 0;
   localparam int unsigned IRQ_UNDERFLOW = 1;
   localparam int unsigned IRQ_AF_RISE   = 2;
   localparam int unsigned IRQ_AE_RISE   = 3;
   localparam int unsigned IRQ_BITS      = 4;

   // STATUS register field offsets
   localparam int unsigned ST_EMPTY        = 0;
   localparam int unsigned ST_FULL         = 1;
   localparam int unsigned ST_ALMOST_EMPTY = 2;
   localparam int unsigned ST_ALMOST_FULL  = 3;
   localparam int unsigned ST_LEVEL_LSB    = 8;

   // CONTROL register bits
   localparam int unsigned CTRL_FLUSH = 0;

endpackage

// File: rtl/fifo_ring_buf.sv
// -----------------------------------------------------------------------------
// fifo_ring_buf
// Circular FIFO storage of 2**ADDR_WIDTH words with wrapping read/write
// pointers and a separate fill-level counter.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   push, push_data     write push_data at the tail (ignored when full)
//   pop                 drop the head word (ignored when empty)
//   flush               empty the FIFO (pointers and level to 0)
//   head                current head word (stale when empty)
//   full, empty         level == DEPTH / level == 0
//   level               number of stored words, 0..DEPTH
// -----------------------------------------------------------------------------
module fifo_ring_buf #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic                  pop,
   input  logic                  flush,
   input  logic [DATA_WIDTH-1:0] push_data,
   output logic [DATA_WIDTH-1:0] head,
   output logic                  full,
   output logic                  empty,
   output logic [ADDR_WIDTH:0]   level
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] LEVEL_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic                  do_push;
   logic                  do_pop;

   assign full  = (level == LEVEL_FULL);
   assign empty = (level == '0);
   assign head  = mem[rd_ptr];

   // Flush takes priority so a same-cycle push/pop cannot survive it.
   assign do_push = push && !full  && !flush;
   assign do_pop  = pop  && !empty && !flush;

   // Storage carries no reset: contents are irrelevant while level is 0.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/fifo_csr_irq.sv
// -----------------------------------------------------------------------------
// fifo_csr_irq
// Avalon-MM slave around a private circular FIFO: push/pop through the DATA
// register, fill level and almost-full/almost-empty flags in STATUS,
// programmable thresholds, flush control and a maskable sticky interrupt.
// Reads have a fixed latency of one cycle, marked by avalon_readdatavalid.
//
// Ports:
//   clk, reset             rising-edge clock, synchronous active-high reset
//   avalon_address         register select (0..6 mapped, 7 unmapped)
//   avalon_write/_read     access strobes (no waitrequest)
//   avalon_writedata       write data / word to push
//   avalon_readdata        registered read data, 0 when no read completes
//   avalon_readdatavalid   one-cycle pulse, one cycle after avalon_read
//   irq                    registered |(irq_status & irq_mask)
// -----------------------------------------------------------------------------
module fifo_csr_irq
   import fifo_csr_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [2:0]            avalon_address,
   input  logic                  avalon_write,
   input  logic                  avalon_read,
   input  logic [DATA_WIDTH-1:0] avalon_writedata,
   output logic [DATA_WIDTH-1:0] avalon_readdata,
   output logic                  avalon_readdatavalid,
   output logic                  irq
);

   localparam int unsigned LEVEL_W = ADDR_WIDTH + 1;
   localparam logic [ADDR_WIDTH:0] AF_RESET = {1'b0, {ADDR_WIDTH{1'b1}}};
   localparam logic [ADDR_WIDTH:0] AE_RESET = {{ADDR_WIDTH{1'b0}}, 1'b1};
   // Flag values produced by the reset state (level 0, reset thresholds);
   // loading these into the previous-flag registers avoids a spurious rise.
   localparam logic AF_AT_RESET = (AF_RESET == '0);
   localparam logic AE_AT_RESET = 1'b1;

   logic                  wr_en;
   logic                  rd_en;
   logic                  push;
   logic                  pop;
   logic                  flush;

   logic [DATA_WIDTH-1:0] fifo_head;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [ADDR_WIDTH:0]   fifo_level;

   logic [ADDR_WIDTH:0]   af_thresh;
   logic [ADDR_WIDTH:0]   ae_thresh;
   logic [IRQ_BITS-1:0]   irq_mask;
   logic [IRQ_BITS-1:0]   irq_status;
   logic [IRQ_BITS-1:0]   irq_status_next;
   logic [IRQ_BITS-1:0]   irq_set;
   logic [IRQ_BITS-1:0]   irq_w1c;

   logic                  almost_full;
   logic                  almost_empty;
   logic                  af_prev;
   logic                  ae_prev;

   logic [DATA_WIDTH-1:0] rd_value;

   // A read colliding with a write is not performed: the write wins and the
   // read completes with 0, so it must not pop or flag underflow.
   assign wr_en = avalon_write;
   assign rd_en = avalon_read && !avalon_write;

   assign push  = wr_en && (avalon_address == DATA);
   assign pop   = rd_en && (avalon_address == DATA);
   assign flush = wr_en && (avalon_address == CONTROL) && avalon_writedata[CTRL_FLUSH];

   fifo_ring_buf #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ring (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .pop       (pop),
      .flush     (flush),
      .push_data (avalon_writedata),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

   assign almost_full  = (fifo_level >= af_thresh);
   assign almost_empty = (fifo_level <= ae_thresh);

   always_comb begin
      irq_set                = '0;
      irq_set[IRQ_OVERFLOW]  = push && fifo_full;
      irq_set[IRQ_UNDERFLOW] = pop && fifo_empty;
      irq_set[IRQ_AF_RISE]   = almost_full && !af_prev;
      irq_set[IRQ_AE_RISE]   = almost_empty && !ae_prev;

      irq_w1c = '0;
      if (wr_en && (avalon_address == IRQ_STATUS)) begin
         irq_w1c = avalon_writedata[IRQ_BITS-1:0];
      end

      // OR-ing the set term last lets a same-cycle event beat the clear.
      irq_status_next = (irq_status & ~irq_w1c) | irq_set;
   end

   always_comb begin
      rd_value = '0;
      case (avalon_address)
         STATUS: begin
            rd_value[ST_EMPTY]                      = fifo_empty;
            rd_value[ST_FULL]                       = fifo_full;
            rd_value[ST_ALMOST_EMPTY]               = almost_empty;
            rd_value[ST_ALMOST_FULL]                = almost_full;
            rd_value[ST_LEVEL_LSB +: LEVEL_W]       = fifo_level;
         end
         DATA: begin
            if (!fifo_empty) begin
               rd_value = fifo_head;
            end
         end
         AF_THRESH:  rd_value[ADDR_WIDTH:0] = af_thresh;
         AE_THRESH:  rd_value[ADDR_WIDTH:0] = ae_thresh;
         IRQ_MASK:   rd_value[IRQ_BITS-1:0] = irq_mask;
         IRQ_STATUS: rd_value[IRQ_BITS-1:0] = irq_status;
         default:    rd_value = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         af_thresh            <= AF_RESET;
         ae_thresh            <= AE_RESET;
         irq_mask             <= '0;
         irq_status           <= '0;
         af_prev              <= AF_AT_RESET;
         ae_prev              <= AE_AT_RESET;
         avalon_readdata      <= '0;
         avalon_readdatavalid <= 1'b0;
         irq                  <= 1'b0;
      end else begin
         if (wr_en) begin
            case (avalon_address)
               AF_THRESH: af_thresh <= avalon_writedata[ADDR_WIDTH:0];
               AE_THRESH: ae_thresh <= avalon_writedata[ADDR_WIDTH:0];
               IRQ_MASK:  irq_mask  <= avalon_writedata[IRQ_BITS-1:0];
               default:   ;
            endcase
         end
         irq_status           <= irq_status_next;
         af_prev              <= almost_full;
         ae_prev              <= almost_empty;
         avalon_readdatavalid <= avalon_read;
         avalon_readdata      <= rd_en ? rd_value : '0;
         irq                  <= |(irq_status & irq_mask);
      end
   end

endmodule

// File: tb/tb_fifo_csr_irq.sv
// -----------------------------------------------------------------------------
// tb_fifo_csr_irq
// Self-checking bench for fifo_csr_irq (DATA_WIDTH 32, ADDR_WIDTH 4).
// A queue-based reference model predicts readdata, readdatavalid and irq for
// every cycle; directed scenarios add literal checks on key register values,
// followed by a randomized access phase.
// -----------------------------------------------------------------------------
module tb_fifo_csr_irq;

   localparam int unsigned DW    = 32;
   localparam int unsigned AW    = 4;
   localparam int unsigned DEPTH = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic [2:0]    avalon_address;
   logic          avalon_write;
   logic          avalon_read;
   logic [DW-1:0] avalon_writedata;
   logic [DW-1:0] avalon_readdata;
   logic          avalon_readdatavalid;
   logic          irq;

   always #5 clk = ~clk;

   fifo_csr_irq #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW)
   ) dut (
      .clk                  (clk),
      .reset                (reset),
      .avalon_address       (avalon_address),
      .avalon_write         (avalon_write),
      .avalon_read          (avalon_read),
      .avalon_writedata     (avalon_writedata),
      .avalon_readdata      (avalon_readdata),
      .avalon_readdatavalid (avalon_readdatavalid),
      .irq                  (irq)
   );

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [31:0] m_q [$];
   int unsigned m_af;
   int unsigned m_ae;
   bit   [3:0]  m_mask;
   bit   [3:0]  m_ists;
   bit          m_prev_af;
   bit          m_prev_ae;
   bit          m_irq;
   bit          m_rdv;
   logic [31:0] m_rd;

   // Advance the model by one clock edge given the inputs of that cycle.
   task automatic model_step(bit rst, bit w, bit r, bit [2:0] a, logic [31:0] d);
      int unsigned lvl;
      bit          af;
      bit          ae;
      bit   [3:0]  set;
      bit   [3:0]  w1c;
      bit          nirq;
      if (rst) begin
         m_q.delete();
         m_af      = DEPTH - 1;
         m_ae      = 1;
         m_mask    = '0;
         m_ists    = '0;
         m_prev_af = (0 >= DEPTH - 1);
         m_prev_ae = 1'b1;
         m_irq     = 1'b0;
         m_rdv     = 1'b0;
         m_rd      = '0;
         return;
      end
      lvl  = m_q.size();
      af   = (lvl >= m_af);
      ae   = (lvl <= m_ae);
      set  = '0;
      w1c  = '0;
      if (af && !m_prev_af) set[2] = 1'b1;
      if (ae && !m_prev_ae) set[3] = 1'b1;
      nirq  = |(m_ists & m_mask);
      m_rdv = r;
      m_rd  = '0;
      if (r && !w) begin
         case (a)
            3'd0: begin
               m_rd[0]    = (lvl == 0);
               m_rd[1]    = (lvl == DEPTH);
               m_rd[2]    = ae;
               m_rd[3]    = af;
               m_rd[12:8] = lvl[4:0];
            end
            3'd1: begin
               if (lvl == 0) set[1] = 1'b1;
               else          m_rd = m_q.pop_front();
            end
            3'd2: m_rd = m_af;
            3'd3: m_rd = m_ae;
            3'd4: m_rd = {28'b0, m_mask};
            3'd5: m_rd = {28'b0, m_ists};
            default: m_rd = '0;
         endcase
      end
      if (w) begin
         case (a)
            3'd1: begin
               if (lvl == DEPTH) set[0] = 1'b1;
               else              m_q.push_back(d);
            end
            3'd2: m_af   = d[4:0];
            3'd3: m_ae   = d[4:0];
            3'd4: m_mask = d[3:0];
            3'd5: w1c    = d[3:0];
            3'd6: if (d[0]) m_q.delete();
            default: ;
         endcase
      end
      m_ists    = (m_ists & ~w1c) | set;
      m_prev_af = af;
      m_prev_ae = ae;
      m_irq     = nirq;
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic cycle(bit rst, bit w, bit r, bit [2:0] a, logic [31:0] d);
      reset            = rst;
      avalon_write     = w;
      avalon_read      = r;
      avalon_address   = a;
      avalon_writedata = d;
      @(posedge clk);
      model_step(rst, w, r, a, d);
      #1;
      check("readdatavalid", {31'b0, avalon_readdatavalid}, {31'b0, m_rdv});
      if (m_rdv) check("readdata", avalon_readdata, m_rd);
      check("irq", {31'b0, irq}, {31'b0, m_irq});
   endtask

   task automatic wr(bit [2:0] a, logic [31:0] d);
      cycle(1'b0, 1'b1, 1'b0, a, d);
   endtask

   task automatic rd(bit [2:0] a, output logic [31:0] v);
      cycle(1'b0, 1'b0, 1'b1, a, '0);
      v = avalon_readdata;
   endtask

   task automatic idle();
      cycle(1'b0, 1'b0, 1'b0, 3'd0, '0);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      logic [31:0]  v;
      int unsigned  sel;
      logic [31:0]  d;
      logic [2:0]   a;

      cycle(1'b1, 1'b0, 1'b0, 3'd0, '0);
      cycle(1'b1, 1'b0, 1'b0, 3'd0, '0);

      // Reset state
      rd(3'd0, v);
      check("status_after_reset", v, 32'h0000_0005);
      check("irq_after_reset", {31'b0, irq}, 32'h0);

      // Fill, drain in order, twice (second pass wraps pointers)
      for (int p = 0; p < 2; p++) begin
         for (int i = 0; i < 16; i++) wr(3'd1, 32'hA1 + i);
         rd(3'd0, v);
         check("status_full", v, 32'h0000_100A);
         for (int i = 0; i < 16; i++) begin
            rd(3'd1, v);
            check("pop_order", v, 32'hA1 + i);
         end
      end

      // Overflow interrupt
      wr(3'd5, 32'hF);
      wr(3'd4, 32'h1);
      for (int i = 0; i < 17; i++) wr(3'd1, 32'hC0 + i);
      check("irq_one_after_ovf", {31'b0, irq}, 32'h0);
      idle();
      check("irq_two_after_ovf", {31'b0, irq}, 32'h1);
      rd(3'd5, v);
      check("ovf_status_bit", {31'b0, v[0]}, 32'h1);
      wr(3'd5, 32'h1);
      idle();
      check("irq_after_w1c", {31'b0, irq}, 32'h0);
      for (int i = 0; i < 16; i++) begin
         rd(3'd1, v);
         check("pop_after_ovf", v, 32'hC0 + i);
      end

      // Almost-full rise
      wr(3'd5, 32'hF);
      wr(3'd2, 32'd4);
      wr(3'd4, 32'h4);
      for (int i = 0; i < 3; i++) wr(3'd1, 32'hD0 + i);
      idle();
      rd(3'd5, v);
      check("af_not_yet", {31'b0, v[2]}, 32'h0);
      wr(3'd1, 32'hD3);
      idle();
      rd(3'd5, v);
      check("af_rise", {31'b0, v[2]}, 32'h1);
      check("af_irq", {31'b0, irq}, 32'h1);
      wr(3'd5, 32'h4);
      wr(3'd1, 32'hD4);
      idle();
      rd(3'd5, v);
      check("af_no_reset", {31'b0, v[2]}, 32'h0);

      // Underflow
      for (int i = 0; i < 5; i++) rd(3'd1, v);
      wr(3'd5, 32'hF);
      rd(3'd1, v);
      check("pop_empty_data", v, 32'h0);
      rd(3'd5, v);
      check("udf_status_bit", {31'b0, v[1]}, 32'h1);
      rd(3'd0, v);
      check("status_after_udf", v, 32'h0000_0005);

      // Flush
      for (int i = 0; i < 5; i++) wr(3'd1, 32'hE0 + i);
      wr(3'd5, 32'hF);
      wr(3'd6, 32'h1);
      rd(3'd0, v);
      check("status_after_flush", v, 32'h0000_0005);
      rd(3'd5, v);
      check("ae_rise_on_flush", {31'b0, v[3]}, 32'h1);

      // Read and write together: write happens, read returns 0
      $display("protocol error: read and write asserted together at t=%0t (deliberate)", $time);
      cycle(1'b0, 1'b1, 1'b1, 3'd1, 32'h0000_DEAD);
      check("rw_collision_data", avalon_readdata, 32'h0);
      rd(3'd1, v);
      check("rw_collision_push", v, 32'h0000_DEAD);

      // Reset mid-burst suppresses pending readdatavalid
      for (int i = 0; i < 3; i++) wr(3'd1, 32'hF0 + i);
      rd(3'd1, v);
      cycle(1'b1, 1'b0, 1'b1, 3'd1, '0);
      check("rst_rdv", {31'b0, avalon_readdatavalid}, 32'h0);
      check("rst_rdata", avalon_readdata, 32'h0);
      check("rst_irq", {31'b0, irq}, 32'h0);
      rd(3'd0, v);
      check("status_after_mid_reset", v, 32'h0000_0005);

      // Randomized phase against the model
      for (int n = 0; n < 3000; n++) begin
         sel = $urandom_range(0, 99);
         d   = $urandom;
         a   = 3'($urandom_range(0, 7));
         if (sel < 1)        cycle(1'b1, 1'b0, 1'b0, 3'd0, '0);
         else if (sel < 36)  wr(3'd1, d);
         else if (sel < 66)  rd(3'd1, v);
         else if (sel < 76)  rd(a, v);
         else if (sel < 80)  wr(3'd2, 32'($urandom_range(0, 17)));
         else if (sel < 84)  wr(3'd3, 32'($urandom_range(0, 17)));
         else if (sel < 87)  wr(3'd4, d);
         else if (sel < 91)  wr(3'd5, d);
         else if (sel < 93)  wr(3'd6, d);
         else if (sel < 94)  wr(3'd7, d);
         else                idle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
